// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the sequencer and the accumulator execute stage.
// The sequencer drives the issue fields; the execute stage returns status and the update record.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 12
);
  logic             start;
  logic [3:0]       opcode_in;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic [WIDTH-1:0] AC;
  logic             AC_update;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] AC_result;

  modport master (
    output start, opcode_in, operand,
    input  busy, AC, AC_update, opcode, op1, op2, AC_result
  );

  modport slave (
    input  start, opcode_in, operand,
    output busy, AC, AC_update, opcode, op1, op2, AC_result
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Accumulator execute stage: single-cycle ALU ops plus a shift-add multiplier,
// publishing a one-cycle update record for flags_setter when each op completes.
module alu_exec_unit #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned MUL_CYCLES = 12
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [3:0] OP_CMP = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b1011;
  localparam logic [3:0] OP_OR  = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;
  localparam logic [3:0] OP_SHL = 4'b1110;
  localparam logic [3:0] OP_SHR = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mul_fin;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] alu_res_c;
  logic             single_op_c;
  logic             prod_hi_unused;

  // Only the low half of the partial product reaches the accumulator.
  assign prod_hi_unused = ^prod[PW-1:WIDTH];

  always_comb begin
    single_op_c = 1'b0;
    case (bus.opcode_in)
      OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: single_op_c = 1'b1;
      default: single_op_c = 1'b0;
    endcase
  end

  // Single-cycle result from the operands latched at issue.
  always_comb begin
    alu_res_c = '0;
    case (bus.opcode)
      OP_ADD:         alu_res_c = bus.op1 + bus.op2;
      OP_SUB, OP_CMP: alu_res_c = bus.op1 - bus.op2;
      OP_AND:         alu_res_c = bus.op1 & bus.op2;
      OP_OR:          alu_res_c = bus.op1 | bus.op2;
      OP_XOR:         alu_res_c = bus.op1 ^ bus.op2;
      OP_SHL:         alu_res_c = bus.op1 << 1;
      OP_SHR:         alu_res_c = bus.op1 >> 1;
      default:        alu_res_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      mul_fin       <= 1'b0;
      mcand         <= '0;
      mplier        <= '0;
      prod          <= '0;
      bus.busy      <= 1'b0;
      bus.AC        <= '0;
      bus.AC_update <= 1'b0;
      bus.opcode    <= '0;
      bus.op1       <= '0;
      bus.op2       <= '0;
      bus.AC_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (single_op_c || bus.opcode_in == OP_MUL)) begin
            bus.op1    <= bus.AC;
            bus.op2    <= bus.operand;
            bus.opcode <= bus.opcode_in;
            bus.busy   <= 1'b1;
            if (bus.opcode_in == OP_MUL) begin
              mcand   <= {{WIDTH{1'b0}}, bus.operand};
              mplier  <= bus.AC;
              prod    <= '0;
              cnt     <= '0;
              mul_fin <= 1'b0;
              state   <= MUL;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          bus.AC_result <= alu_res_c;
          bus.AC_update <= 1'b1;
          state         <= DONE;
        end
        MUL: begin
          // MUL_CYCLES shift-add steps, then one cycle to publish the product.
          if (mul_fin) begin
            bus.AC_result <= prod[WIDTH-1:0];
            bus.AC_update <= 1'b1;
            state         <= DONE;
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == CNT_W'(MUL_CYCLES - 1)) mul_fin <= 1'b1;
            else                               cnt     <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          bus.AC_update <= 1'b0;
          bus.busy      <= 1'b0;
          if (bus.opcode != OP_CMP) bus.AC <= bus.AC_result;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: transaction-level accumulator model checked every cycle,
// plus directed operations with hand-computed results.
module tb_alu_exec_unit;
  localparam int unsigned W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) ifc();
  alu_exec_unit #(.WIDTH(W), .MUL_CYCLES(12)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_valid(input int unsigned op);
    return op inside {4, 5, 9, 10, 11, 12, 13, 14, 15};
  endfunction

  function automatic int unsigned compute(input int unsigned op, input int unsigned a,
                                          input int unsigned b);
    int unsigned r;
    case (op)
      9:       r = a + b;
      10, 4:   r = a - b;
      11:      r = a & b;
      12:      r = a | b;
      13:      r = a ^ b;
      14:      r = a << 1;
      15:      r = a >> 1;
      5:       r = a * b;
      default: r = a;
    endcase
    return r & 32'hFFF;
  endfunction

  // Model: an accepted op occupies cycles 1..lat after issue, lat being its completion cycle.
  int unsigned m_ac, m_t, m_lat, m_res, pend, m_op, m_op1, m_op2;
  bit m_busy, m_wr;

  always @(posedge clk) begin
    if (rst) begin
      m_ac = 0; m_t = 0; m_lat = 0; m_res = 0; pend = 0;
      m_op = 0; m_op1 = 0; m_op2 = 0; m_busy = 0; m_wr = 0;
    end else if (m_busy) begin
      if (m_t == m_lat) begin
        m_busy = 0;
        if (m_wr) m_ac = m_res;
      end else begin
        m_t++;
        if (m_t == m_lat) m_res = pend;
      end
    end else if (ifc.start && is_valid(32'(ifc.opcode_in))) begin
      m_op1  = m_ac;
      m_op2  = 32'(ifc.operand);
      m_op   = 32'(ifc.opcode_in);
      pend   = compute(m_op, m_op1, m_op2);
      m_wr   = (m_op != 4);
      m_lat  = (m_op == 5) ? 14 : 2;
      m_t    = 1;
      m_busy = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(ifc.busy), 32'(m_busy));
      chk("AC_update", 32'(ifc.AC_update), 32'(m_busy && (m_t == m_lat)));
      chk("AC", 32'(ifc.AC), m_ac);
      chk("AC_result", 32'(ifc.AC_result), m_res);
      chk("opcode", 32'(ifc.opcode), m_op);
      chk("op1", 32'(ifc.op1), m_op1);
      chk("op2", 32'(ifc.op2), m_op2);
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] val, input int exp_lat,
                        input logic [W-1:0] exp_op1, input logic [W-1:0] exp_res,
                        input logic [W-1:0] exp_ac, input bit spam);
    int n;
    int nb;
    @(negedge clk);
    ifc.start = 1'b1; ifc.opcode_in = op; ifc.operand = val;
    @(negedge clk);
    ifc.start = 1'b0; ifc.opcode_in = 4'h0; ifc.operand = '0;
    n  = 1;
    nb = 0;
    while (1) begin
      if (ifc.busy) nb++;
      if (ifc.AC_update || n >= 40) break;
      if (spam) begin
        ifc.start = 1'b1; ifc.opcode_in = 4'b1001; ifc.operand = W'($urandom_range(0, 4095));
      end
      @(negedge clk);
      n++;
    end
    ifc.start = 1'b0; ifc.opcode_in = 4'h0; ifc.operand = '0;
    chk("latency", 32'(n), 32'(exp_lat));
    chk("busy_cycles", 32'(nb), 32'(exp_lat));
    chk("lit_AC_result", 32'(ifc.AC_result), 32'(exp_res));
    chk("lit_op1", 32'(ifc.op1), 32'(exp_op1));
    chk("lit_op2", 32'(ifc.op2), 32'(val));
    chk("lit_opcode", 32'(ifc.opcode), 32'(op));
    @(negedge clk);
    chk("lit_update_single", 32'(ifc.AC_update), 32'(0));
    chk("lit_AC_after", 32'(ifc.AC), 32'(exp_ac));
  endtask

  initial begin
    int upd;
    rst = 1'b1;
    ifc.start = 1'b0; ifc.opcode_in = 4'h0; ifc.operand = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_AC", 32'(ifc.AC), 32'(0));
    chk("rst_busy", 32'(ifc.busy), 32'(0));
    chk("rst_update", 32'(ifc.AC_update), 32'(0));
    chk("rst_ops", 32'({ifc.op1, ifc.op2, ifc.AC_result}), 32'(0));
    rst = 1'b0;

    run_op(4'b1010, 12'h001, 2, 12'h000, 12'hFFF, 12'hFFF, 1'b0); // SUB -> 0xFFF
    run_op(4'b1001, 12'h001, 2, 12'hFFF, 12'h000, 12'h000, 1'b0); // ADD wraps
    run_op(4'b1100, 12'h005, 2, 12'h000, 12'h005, 12'h005, 1'b0); // OR
    run_op(4'b0100, 12'h002, 2, 12'h005, 12'h003, 12'h005, 1'b0); // CMP, AC kept
    run_op(4'b1010, 12'h002, 2, 12'h005, 12'h003, 12'h003, 1'b0); // SUB
    run_op(4'b0101, 12'h005, 14, 12'h003, 12'h00F, 12'h00F, 1'b1); // MUL with spam starts
    run_op(4'b1011, 12'h000, 2, 12'h00F, 12'h000, 12'h000, 1'b0); // AND
    run_op(4'b1100, 12'h7FF, 2, 12'h000, 12'h7FF, 12'h7FF, 1'b0);
    run_op(4'b1001, 12'h001, 2, 12'h7FF, 12'h800, 12'h800, 1'b0);
    run_op(4'b1110, 12'h000, 2, 12'h800, 12'h000, 12'h000, 1'b0); // SHL drops MSB
    run_op(4'b1100, 12'hA5A, 2, 12'h000, 12'hA5A, 12'hA5A, 1'b0);
    run_op(4'b1101, 12'hFFF, 2, 12'hA5A, 12'h5A5, 12'h5A5, 1'b0); // XOR
    run_op(4'b1111, 12'h000, 2, 12'h5A5, 12'h2D2, 12'h2D2, 1'b0); // SHR logical
    run_op(4'b1100, 12'hFFF, 2, 12'h2D2, 12'hFFF, 12'hFFF, 1'b0);
    run_op(4'b0101, 12'hFFF, 14, 12'hFFF, 12'h001, 12'h001, 1'b0); // MUL wraps

    // Undefined opcode: no strobe, never busy.
    @(negedge clk);
    ifc.start = 1'b1; ifc.opcode_in = 4'h6; ifc.operand = 12'h123;
    @(negedge clk);
    ifc.start = 1'b0; ifc.opcode_in = 4'h0;
    for (int i = 0; i < 3; i++) begin
      chk("undef_busy", 32'(ifc.busy), 32'(0));
      chk("undef_update", 32'(ifc.AC_update), 32'(0));
      chk("undef_AC", 32'(ifc.AC), 32'(12'h001));
      @(negedge clk);
    end

    // Reset in the middle of a multiply aborts it silently.
    run_op(4'b1011, 12'h000, 2, 12'h001, 12'h000, 12'h000, 1'b0);
    run_op(4'b1100, 12'h003, 2, 12'h000, 12'h003, 12'h003, 1'b0);
    @(negedge clk);
    ifc.start = 1'b1; ifc.opcode_in = 4'b0101; ifc.operand = 12'h005;
    @(negedge clk);
    ifc.start = 1'b0; ifc.opcode_in = 4'h0;
    repeat (5) @(negedge clk);
    chk("mul_busy_before_rst", 32'(ifc.busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_AC", 32'(ifc.AC), 32'(0));
    chk("abort_busy", 32'(ifc.busy), 32'(0));
    rst = 1'b0;
    upd = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.AC_update) upd++;
    end
    chk("abort_no_update", 32'(upd), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
